tone_scheduler: RTL
===================

TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 Parameter SONG_LEN, default 32: number of song table entries; legal range 2..32.
REQ-002 Parameter LOOP, default 0: 1 = restart at entry 0 after the last entry; 0 = stop.
REQ-003 CLK  input  1  system clock; the same clock as the note/beat clock manager.
REQ-004 RESET_N  input  1  reset; asynchronous assert, active-low.
REQ-005 NOTE_CLK  input  8  note square waves; bit0=C4, D, E, F, G, A, B, bit7=C5.
REQ-006 QUARTER_BEAT  input  1  beat square wave; each rising edge is one beat tick.
REQ-007 KEY  input  8  manual piano keys, level, synchronous to CLK; bit mapping as NOTE_CLK.
REQ-008 PLAY_PAUSE  input  1  single-cycle command pulse.
REQ-009 STOP  input  1  single-cycle command pulse.
REQ-010 SPEAKER  output  1  registered audio output.
REQ-011 ACTIVE_NOTE  output  4  code of the sounding note; 0 = silence.
REQ-012 STATE  output  2  IDLE=0, PLAYING=1, PAUSED=2.
REQ-013 SONG_POS  output  5  current song table index.
REQ-014 DONE  output  1  one-cycle pulse at song end.

Function
REQ-015 Song entry SHALL be 6 bits: {dur[1:0], note[3:0]}.
  - note 0 = rest; 1..8 = NOTE_CLK[note-1]; 15 = END marker; 9..14 = rest.
  - Duration SHALL be dur+1 beats (1..4).
REQ-016 Beat tick SHALL be QUARTER_BEAT high with its previous-cycle registered value low.
REQ-017 IDLE + PLAY_PAUSE:
  - Go to PLAYING; SONG_POS=0.
  - Load entry 0; beat counter = dur+1.
REQ-018 PLAYING + PLAY_PAUSE: go to PAUSED; SONG_POS and beat counter held.
REQ-019 PAUSED + PLAY_PAUSE: go to PLAYING; resume with retained SONG_POS and beat counter.
REQ-020 STOP in any state:
  - Go to IDLE; SONG_POS=0.
  - STOP SHALL win over a same-cycle PLAY_PAUSE or beat tick.
REQ-021 PLAYING + beat tick + KEY==0: beat counter decrements.
  - When the counter is 1 at the tick, advance SONG_POS and load the next entry instead.
REQ-022 End of song: advancing onto an END entry, or past SONG_LEN-1.
  - LOOP=1: SONG_POS=0 and entry 0 is loaded.
  - LOOP=0: go to IDLE, SONG_POS=0.
  - Either case: DONE=1 for exactly that cycle.
REQ-023 Entry 0 equal to END SHALL return to IDLE with a DONE pulse on the cycle after PLAY_PAUSE.
REQ-024 Manual override:
  - While any KEY bit is high, the lowest set KEY index SHALL sound, regardless of STATE.
  - Beat ticks SHALL be ignored, freezing song progress.
REQ-025 SPEAKER SHALL be registered with one cycle of latency, selected as:
  - override: NOTE_CLK[lowest key];
  - else PLAYING with note 1..8: NOTE_CLK[note-1];
  - else 0.
REQ-026 ACTIVE_NOTE SHALL show the selected code with the same one-cycle latency (override code = key index+1).
REQ-027 A PLAY_PAUSE, STOP or beat tick coinciding with a KEY change SHALL be processed normally; KEY gates only ticks (REQ-024).

Reset
REQ-028 RESET_N low SHALL immediately force:
  - STATE=IDLE, SONG_POS=0, beat counter=0, previous-beat register=0;
  - SPEAKER=0, ACTIVE_NOTE=0, DONE=0.
REQ-029 Reset mid-song SHALL discard position; after release, the first PLAY_PAUSE starts at entry 0.

Structure
REQ-030 Shared package tone_pkg SHALL hold:
  - state encoding;
  - note codes (REST=0, C4=1 .. C5=8, END=15);
  - entry width 6 and maximum depth 32.
REQ-031 Song table SHALL be a separate sub-module song_rom: combinational 5-bit address in, 6-bit entry out, 32 entries.
  - Unused entries = END.

Verification
REQ-032 Reset, then PLAY_PAUSE with entry0={1,C4}, entry1={0,E}: SPEAKER follows NOTE_CLK[0] for 2 beat ticks, then NOTE_CLK[2]; SONG_POS 0->1.
REQ-033 PAUSE/resume: PLAY_PAUSE at SONG_POS=3 -> STATE=2, SPEAKER=0, 3 ticks ignored; PLAY_PAUSE -> STATE=1, SONG_POS=3, remaining beats unchanged.
REQ-034 KEY=8'b0010_0100 during PLAYING -> SPEAKER=NOTE_CLK[2], ACTIVE_NOTE=3, SONG_POS frozen across 2 ticks; KEY=0 -> song note resumes next cycle.
REQ-035 STOP and PLAY_PAUSE in the same cycle while PLAYING -> STATE=0, SONG_POS=0, SPEAKER=0 next cycle.
REQ-036 END at entry 4: LOOP=0 -> DONE pulse, STATE=0, SONG_POS=0; LOOP=1 -> DONE pulse, STATE=1, SONG_POS=0.
REQ-037 RESET_N asserted mid-note, between clock edges -> all outputs 0 before the next CLK edge.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: shared state encoding, note codes, song-entry layout and default song
package tone_pkg;
  localparam int ENTRY_W = 6;
  localparam int MAX_DEPTH = 32;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2
  } state_t;
  typedef struct packed {
    logic [1:0] dur;
    logic [3:0] note;
  } entry_t;
  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4 = 4'd1;
  localparam logic [3:0] NOTE_D4 = 4'd2;
  localparam logic [3:0] NOTE_E4 = 4'd3;
  localparam logic [3:0] NOTE_F4 = 4'd4;
  localparam logic [3:0] NOTE_G4 = 4'd5;
  localparam logic [3:0] NOTE_A4 = 4'd6;
  localparam logic [3:0] NOTE_B4 = 4'd7;
  localparam logic [3:0] NOTE_C5 = 4'd8;
  localparam logic [3:0] NOTE_END = 4'd15;
  // Entry i lives at bits [i*ENTRY_W +: ENTRY_W]; entries 0..3 form a short tune, the rest are END.
  localparam logic [MAX_DEPTH*ENTRY_W-1:0] DEFAULT_SONG = {
    {28{2'd0, NOTE_END}}, 2'd2, NOTE_C5, 2'd3, NOTE_G4, 2'd0, NOTE_E4, 2'd1, NOTE_C4
  };
  function automatic logic [2:0] low_idx(input logic [7:0] v);
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) low_idx = 3'(i);
  endfunction
endpackage

// File: rtl/song_rom.sv
// song_rom: 32-entry combinational song table
//   addr  : entry index
//   entry : {dur[1:0], note[3:0]}
module song_rom
  import tone_pkg::*;
#(
  parameter logic [MAX_DEPTH*ENTRY_W-1:0] SONG = DEFAULT_SONG
) (
  input  logic [4:0] addr,
  output entry_t     entry
);
  entry_t rom [MAX_DEPTH];
  for (genvar i = 0; i < MAX_DEPTH; i++) begin : g_rom
    assign rom[i] = SONG[i*ENTRY_W +: ENTRY_W];
  end
  assign entry = rom[addr];
endmodule

// File: rtl/tone_scheduler.sv
// tone_scheduler: song sequencer with pause/stop, manual key override and registered speaker
//   CLK, RESET_N     : clock, async active-low reset
//   NOTE_CLK         : note square waves C4..C5
//   QUARTER_BEAT     : beat square wave, rising edge = one tick
//   KEY              : manual keys, lowest set index wins
//   PLAY_PAUSE, STOP : one-cycle commands
//   SPEAKER, ACTIVE_NOTE, STATE, SONG_POS, DONE : status and audio
module tone_scheduler
  import tone_pkg::*;
#(
  parameter int SONG_LEN = 32,
  parameter bit LOOP = 1'b0,
  parameter logic [MAX_DEPTH*ENTRY_W-1:0] SONG = DEFAULT_SONG
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] NOTE_CLK,
  input  logic       QUARTER_BEAT,
  input  logic [7:0] KEY,
  input  logic       PLAY_PAUSE,
  input  logic       STOP,
  output logic       SPEAKER,
  output logic [3:0] ACTIVE_NOTE,
  output logic [1:0] STATE,
  output logic [4:0] SONG_POS,
  output logic       DONE
);
  localparam logic [4:0] LAST = 5'(SONG_LEN - 1);
  state_t state, state_d;
  logic [4:0] pos, pos_d;
  logic [2:0] cnt, cnt_d;
  logic [3:0] note, note_d, code_d;
  logic [2:0] kidx, nidx;
  logic beat_q, done_d, spk_d, ovr, tick, last, song_on;
  entry_t nxt_e, first_e;
  // note holds the note of the loaded entry, so the table is only read for the next and first entries
  song_rom #(.SONG(SONG)) u_nxt (.addr(pos + 5'd1), .entry(nxt_e));
  song_rom #(.SONG(SONG)) u_first (.addr(5'd0), .entry(first_e));
  assign ovr = |KEY;
  assign tick = QUARTER_BEAT & ~beat_q & ~ovr;
  assign last = pos == LAST || nxt_e.note == NOTE_END;
  assign kidx = low_idx(KEY);
  assign nidx = 3'(note - 4'd1);
  assign song_on = state == PLAYING && note >= NOTE_C4 && note <= NOTE_C5;
  assign spk_d = ovr ? NOTE_CLK[kidx] : song_on & NOTE_CLK[nidx];
  assign code_d = ovr ? {1'b0, kidx} + 4'd1 : song_on ? note : NOTE_REST;
  assign STATE = state;
  assign SONG_POS = pos;
  always_comb begin
    state_d = state;
    pos_d = pos;
    cnt_d = cnt;
    note_d = note;
    done_d = 1'b0;
    if (STOP) begin
      state_d = IDLE;
      pos_d = '0;
      cnt_d = '0;
    end else if (state == IDLE) begin
      // an END at entry 0 finishes immediately without ever entering PLAYING
      if (PLAY_PAUSE && first_e.note == NOTE_END) done_d = 1'b1;
      else if (PLAY_PAUSE) begin
        state_d = PLAYING;
        pos_d = '0;
        cnt_d = {1'b0, first_e.dur} + 3'd1;
        note_d = first_e.note;
      end
    end else if (state == PAUSED) begin
      if (PLAY_PAUSE) state_d = PLAYING;
    end else if (PLAY_PAUSE) state_d = PAUSED;
    else if (tick) begin
      if (cnt > 3'd1) cnt_d = cnt - 3'd1;
      else if (!last) begin
        pos_d = pos + 5'd1;
        cnt_d = {1'b0, nxt_e.dur} + 3'd1;
        note_d = nxt_e.note;
      end else begin
        done_d = 1'b1;
        pos_d = '0;
        if (LOOP) begin
          cnt_d = {1'b0, first_e.dur} + 3'd1;
          note_d = first_e.note;
        end else begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      pos <= '0;
      cnt <= '0;
      note <= NOTE_REST;
      beat_q <= 1'b0;
      SPEAKER <= 1'b0;
      ACTIVE_NOTE <= '0;
      DONE <= 1'b0;
    end else begin
      state <= state_d;
      pos <= pos_d;
      cnt <= cnt_d;
      note <= note_d;
      beat_q <= QUARTER_BEAT;
      SPEAKER <= spk_d;
      ACTIVE_NOTE <= code_d;
      DONE <= done_d;
    end
  end
endmodule
